uart_rx_multi_frame: RTL and testbench
======================================

// Module: uart_rx_multi_frame
// PURPOSE
//  Parametrised UART receiver that succeeds the fixed 8-bit RX in the UART_CLK domain of SYS_TOP.
//  Adds the following over the fixed RX:
//   - DATA_WIDTH-bit frames and optional 2 stop bits.
//   - Majority-vote sampling.
//   - Frame-start glitch rejection.
//   - A per-frame latched configuration.
//  Feeds SYS_CTRL with P_DATA/DATA_VLD and reports parity and framing errors.
// PARAMETERS
//  DATA_WIDTH      8   data bits per frame, legal range 5..9, LSB first
//  PRESCALE_WIDTH  6   width of Prescale; legal oversampling values are 8, 16 and 32
// PORTS
//  CLK        in   1               UART oversampling clock (UART_CLK domain); single clock
//  RST_N      in   1               asynchronous, active-low reset
//  RX_IN      in   1               serial line; idle is high
//  PAR_EN     in   1               1: a parity bit follows the data bits
//  PAR_TYP    in   1               0: even parity, 1: odd parity
//  STOP2_EN   in   1               1: two stop bits expected
//  Prescale   in   PRESCALE_WIDTH  oversampling ratio
//  P_DATA     out  DATA_WIDTH      received word
//  DATA_VLD   out  1               1-cycle pulse when a good frame is received
//  PAR_ERR    out  1               1-cycle pulse on parity mismatch
//  STP_ERR    out  1               1-cycle pulse when any stop bit is sampled 0
//  BREAK_DET  out  1               1-cycle pulse on a line break (only with UART_RX_BREAK_DET_EN)
// BEHAVIOUR
//  - Reset: all outputs are 0, FSM is in IDLE, counters are 0, RX sync flops are set to 1 (idle).
//  - RX_IN passes through a 2-flop synchronizer, which adds 2 CLK of latency. All logic uses the synced value.
//  - FSM states: IDLE -> START -> DATA -> [PARITY if PAR_EN] -> STOP1 -> [STOP2 if STOP2_EN] -> IDLE.
//  - Configuration latch: PAR_EN, PAR_TYP, STOP2_EN and Prescale are latched on IDLE->START.
//    Changes to these inputs mid-frame have no effect until the next frame.
//  - Illegal Prescale values (anything other than 8/16/32) are latched as 8.
//  - IDLE -> START on the synced line going 1->0. The edge counter restarts at 0.
//  - Per bit, an edge counter runs 0..P-1, where P is the latched prescale.
//    - Samples are taken at counts P/2-1, P/2 and P/2+1.
//    - The bit value is the majority of the 3 samples, decided at count P/2+2.
//  - START: if the start bit votes 1, it is a glitch; return to IDLE with no flags.
//  - DATA: shift bits LSB-first into a DATA_WIDTH register. The bit counter wraps after DATA_WIDTH bits.
//  - PARITY: expected parity = ^data XOR PAR_TYP. A mismatch sets an internal error flag.
//  - STOP bits:
//    - FSM returns to IDLE at the vote of the last stop bit, not at bit end.
//      This means a start edge arriving half a bit later is still caught, so back-to-back frames lose nothing.
//    - The cycle after the last stop vote:
//      - no errors: P_DATA is updated and DATA_VLD pulses;
//      - parity error: PAR_ERR pulses, DATA_VLD stays 0, P_DATA is held;
//      - any stop bit was 0: STP_ERR pulses, DATA_VLD stays 0, P_DATA is held.
//    - PAR_ERR and STP_ERR can pulse in the same cycle.
//  - Latency: DATA_VLD pulses P/2+3 CLK after the start of the last stop bit on the synced line.
//  - P_DATA holds its value between frames. It changes only on the DATA_VLD cycle.
//  - Reset asserted mid-frame: immediate abort, no pulses. The partial frame is discarded.
// CONFIGURATION
//  Macro: UART_RX_BREAK_DET_EN
//  - Defined:
//    - The BREAK_DET port exists.
//    - A frame whose start, all data bits, parity (if enabled) and all stop bits vote 0 is a break.
//    - On a break: BREAK_DET pulses and STP_ERR/PAR_ERR/DATA_VLD are suppressed.
//    - The FSM then waits in IDLE for the line to return high before accepting a new start edge.
//  - Not defined:
//    - The BREAK_DET port is absent.
//    - An all-zero frame is reported as STP_ERR (plus PAR_ERR if parity mismatches).
// STRUCTURE
//  Package uart_pkg:
//  - rx_state_e enum;
//  - PAR_EVEN and PAR_ODD constants;
//  - PRESCALE_8/16/32 constants;
//  - a function legal_prescale() returning the latched value.
//  Sub-module uart_rx_sampler:
//  - contains the edge counter, the 3-sample majority vote and the bit_done/bit_val strobes;
//  - is parametrised by PRESCALE_WIDTH.
//  The top level holds the synchronizer, the FSM, the shift register, the parity check and the flags.
// TESTING
//  1. Prescale=32, 8N1, send 0xA5:
//     -> P_DATA=0xA5, one DATA_VLD pulse, no errors.
//  2. Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x41 with parity bit 1 (wrong):
//     -> PAR_ERR pulse, no DATA_VLD, P_DATA keeps its previous value.
//  3. Prescale=8, stop bit forced 0 on 0x3C:
//     -> STP_ERR pulse.
//     Then send 0x3C correctly back-to-back:
//     -> DATA_VLD with P_DATA=0x3C.
//  4. Start bit low for 2 CLK only (Prescale=16):
//     -> returns to IDLE, no pulses.
//     Then a valid 0x5A frame:
//     -> DATA_VLD with P_DATA=0x5A.
//  5. DATA_WIDTH=9, STOP2_EN=1, send 9'h1F3, with the second stop bit=0:
//     -> STP_ERR.
//     Resend with both stop bits=1:
//     -> P_DATA=9'h1F3.
//  6. Assert RST_N=0 during data bit 4, then release:
//     -> all outputs are 0, no pulse.
//     Next frame 0x81:
//     -> received correctly.
//     With UART_RX_BREAK_DET_EN, send an all-zero line:
//     -> BREAK_DET only.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the multi-frame UART receiver.
//   rx_state_e       : receiver FSM states
//   PAR_EVEN/PAR_ODD : values of the PAR_TYP input
//   PRESCALE_8/16/32 : the supported oversampling ratios
//   legal_prescale() : maps a requested ratio onto a supported one (anything else becomes 8)
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  function automatic int unsigned legal_prescale(input int unsigned prescale);
    int unsigned result;
    case (prescale)
      PRESCALE_16: result = PRESCALE_16;
      PRESCALE_32: result = PRESCALE_32;
      default:     result = PRESCALE_8;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling engine for the UART receiver.
// An edge counter runs 0..P-1 (P = i_prescale) and wraps continuously while a frame is in flight.
// The line is sampled at counts P/2-1, P/2 and P/2+1; at count P/2+2 the majority of those three
// samples is presented on o_bit_val together with a one-cycle o_bit_done strobe.
// Ports:
//   i_clk      in  1               oversampling clock
//   i_rst_n    in  1               asynchronous active-low reset
//   i_rx       in  1               synchronised serial line
//   i_clear    in  1               hold the edge counter at 0 (receiver idle)
//   i_prescale in  PRESCALE_WIDTH  latched oversampling ratio (8, 16 or 32)
//   o_bit_done out 1               vote strobe at count P/2+2
//   o_bit_val  out 1               majority value, valid with o_bit_done
module uart_rx_sampler #(
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_rx,
  input  logic                      i_clear,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_bit_done,
  output logic                      o_bit_val
);

  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic [PRESCALE_WIDTH-1:0] w_cnt_d;
  logic [PRESCALE_WIDTH-1:0] w_half;
  logic [2:0]                r_smp;

  assign w_half = i_prescale >> 1;

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_clear) begin
      w_cnt_d = '0;
    end else if (r_cnt == i_prescale - PRESCALE_WIDTH'(1)) begin
      w_cnt_d = '0;
    end else begin
      w_cnt_d = r_cnt + PRESCALE_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_smp <= 3'b111;
    end else begin
      r_cnt <= w_cnt_d;
      if (r_cnt == w_half - PRESCALE_WIDTH'(1)) r_smp[0] <= i_rx;
      if (r_cnt == w_half)                      r_smp[1] <= i_rx;
      if (r_cnt == w_half + PRESCALE_WIDTH'(1)) r_smp[2] <= i_rx;
    end
  end

  // Decided one count after the last sample so all three are registered.
  assign o_bit_done = (r_cnt == w_half + PRESCALE_WIDTH'(2));
  assign o_bit_val  = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);

endmodule

// File: rtl/uart_rx_multi_frame.sv
// Parametrised UART receiver: DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits,
// 3-sample majority voting, start-glitch rejection and a configuration latched per frame.
// Optional feature macro: UART_RX_BREAK_DET_EN (adds BREAK_DET and all-zero frame detection).
// Ports:
//   CLK       in  1               oversampling clock
//   RST_N     in  1               asynchronous active-low reset
//   RX_IN     in  1               serial line, idle high
//   PAR_EN    in  1               parity bit present
//   PAR_TYP   in  1               0 even, 1 odd
//   STOP2_EN  in  1               two stop bits
//   Prescale  in  PRESCALE_WIDTH  oversampling ratio (8/16/32, others treated as 8)
//   P_DATA    out DATA_WIDTH      last good word, updated only with DATA_VLD
//   DATA_VLD  out 1               good-frame pulse
//   PAR_ERR   out 1               parity-error pulse
//   STP_ERR   out 1               stop-bit-error pulse
//   BREAK_DET out 1               line-break pulse (UART_RX_BREAK_DET_EN only)
module uart_rx_multi_frame #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      DATA_VLD,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                      BREAK_DET
`endif
);

  import uart_pkg::*;

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  // Synchroniser and edge detect
  logic r_sync1, r_sync2, r_rx_prev;
  logic w_start_edge;

  // FSM and latched configuration
  rx_state_e r_state, w_state_d;
  logic r_par_en, w_par_en_d;
  logic r_par_typ, w_par_typ_d;
  logic r_stop2, w_stop2_d;
  logic [PRESCALE_WIDTH-1:0] r_prescale, w_prescale_d;

  // Datapath
  logic [DATA_WIDTH-1:0] r_shift, w_shift_d;
  logic [BitCntW-1:0]    r_bit_cnt, w_bit_cnt_d;
  logic r_par_err, w_par_err_d;
  logic r_stp_err, w_stp_err_d;
  logic w_frame_end;
  logic w_is_break;

  // Outputs
  logic [DATA_WIDTH-1:0] r_pdata, w_pdata_d;
  logic r_data_vld, w_data_vld_d;
  logic r_par_pulse, w_par_pulse_d;
  logic r_stp_pulse, w_stp_pulse_d;

  // Sampler interface
  logic w_bit_done, w_bit_val, w_clear;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= RX_IN;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // A 1->0 transition is required, so after a break the line must go high before the next start.
  assign w_start_edge = r_rx_prev & ~r_sync2;

  // Counter idles at 0 and also restarts on every return to idle.
  assign w_clear = (w_state_d == StIdle);

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_rx       (r_sync2),
    .i_clear    (w_clear),
    .i_prescale (r_prescale),
    .o_bit_done (w_bit_done),
    .o_bit_val  (w_bit_val)
  );

  always_comb begin
    w_state_d    = r_state;
    w_par_en_d   = r_par_en;
    w_par_typ_d  = r_par_typ;
    w_stop2_d    = r_stop2;
    w_prescale_d = r_prescale;
    w_shift_d    = r_shift;
    w_bit_cnt_d  = r_bit_cnt;
    w_par_err_d  = r_par_err;
    w_stp_err_d  = r_stp_err;
    w_frame_end  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_start_edge) begin
          w_state_d    = StStart;
          w_par_en_d   = PAR_EN;
          w_par_typ_d  = PAR_TYP;
          w_stop2_d    = STOP2_EN;
          w_prescale_d = PRESCALE_WIDTH'(legal_prescale(32'(Prescale)));
          w_bit_cnt_d  = '0;
          w_par_err_d  = 1'b0;
          w_stp_err_d  = 1'b0;
        end
      end
      StStart: begin
        if (w_bit_done) begin
          // A start bit that votes high was noise on the line.
          w_state_d = w_bit_val ? StIdle : StData;
        end
      end
      StData: begin
        if (w_bit_done) begin
          w_shift_d = {w_bit_val, r_shift[DATA_WIDTH-1:1]};
          if (r_bit_cnt == LastBit) begin
            w_bit_cnt_d = '0;
            w_state_d   = r_par_en ? StParity : StStop1;
          end else begin
            w_bit_cnt_d = r_bit_cnt + BitCntW'(1);
          end
        end
      end
      StParity: begin
        if (w_bit_done) begin
          if (w_bit_val != ((^r_shift) ^ r_par_typ)) w_par_err_d = 1'b1;
          w_state_d = StStop1;
        end
      end
      StStop1: begin
        if (w_bit_done) begin
          if (!w_bit_val) w_stp_err_d = 1'b1;
          if (r_stop2) begin
            w_state_d = StStop2;
          end else begin
            w_state_d   = StIdle;
            w_frame_end = 1'b1;
          end
        end
      end
      StStop2: begin
        if (w_bit_done) begin
          if (!w_bit_val) w_stp_err_d = 1'b1;
          w_state_d   = StIdle;
          w_frame_end = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

`ifdef UART_RX_BREAK_DET_EN
  logic r_all_zero, w_all_zero_d;
  logic r_break, w_break_d;

  // Cleared by any bit voting high; still set at the last stop vote means a break.
  always_comb begin
    w_all_zero_d = r_all_zero;
    if (r_state == StIdle && w_start_edge) begin
      w_all_zero_d = 1'b1;
    end else if (w_bit_done && w_bit_val) begin
      w_all_zero_d = 1'b0;
    end
  end

  assign w_is_break = w_all_zero_d;
  assign w_break_d  = w_frame_end & w_is_break;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_all_zero <= 1'b0;
      r_break    <= 1'b0;
    end else begin
      r_all_zero <= w_all_zero_d;
      r_break    <= w_break_d;
    end
  end

  assign BREAK_DET = r_break;
`else
  assign w_is_break = 1'b0;
`endif

  always_comb begin
    w_data_vld_d  = 1'b0;
    w_par_pulse_d = 1'b0;
    w_stp_pulse_d = 1'b0;
    w_pdata_d     = r_pdata;
    if (w_frame_end && !w_is_break) begin
      w_par_pulse_d = w_par_err_d;
      w_stp_pulse_d = w_stp_err_d;
      if (!w_par_err_d && !w_stp_err_d) begin
        w_data_vld_d = 1'b1;
        w_pdata_d    = r_shift;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_par_en    <= 1'b0;
      r_par_typ   <= PAR_EVEN;
      r_stop2     <= 1'b0;
      r_prescale  <= PRESCALE_WIDTH'(PRESCALE_8);
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_par_err   <= 1'b0;
      r_stp_err   <= 1'b0;
      r_pdata     <= '0;
      r_data_vld  <= 1'b0;
      r_par_pulse <= 1'b0;
      r_stp_pulse <= 1'b0;
    end else begin
      r_par_en    <= w_par_en_d;
      r_par_typ   <= w_par_typ_d;
      r_stop2     <= w_stop2_d;
      r_prescale  <= w_prescale_d;
      r_shift     <= w_shift_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_par_err   <= w_par_err_d;
      r_stp_err   <= w_stp_err_d;
      r_pdata     <= w_pdata_d;
      r_data_vld  <= w_data_vld_d;
      r_par_pulse <= w_par_pulse_d;
      r_stp_pulse <= w_stp_pulse_d;
    end
  end

  assign P_DATA   = r_pdata;
  assign DATA_VLD = r_data_vld;
  assign PAR_ERR  = r_par_pulse;
  assign STP_ERR  = r_stp_pulse;

endmodule

// File: tb/tb_uart_rx_multi_frame.sv
// Bench for uart_rx_multi_frame: an 8-bit and a 9-bit instance share clock, reset and config.
// Each frame sent is turned into one expected outcome (cycle, flags, word) from the frame's own
// bits; a negedge process compares both instances against those expectations on every cycle.
`timescale 1ns/1ps
module tb_uart_rx_multi_frame;

  typedef struct {
    int unsigned cyc;
    logic        vld;
    logic        perr;
    logic        serr;
    logic        brk;
    logic [8:0]  data;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx9 = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2_EN = 1'b0;
  logic [5:0] Prescale = 6'd16;

  logic [7:0] pd8;
  logic [8:0] pd9;
  logic vld8, perr8, serr8, brk8;
  logic vld9, perr9, serr9, brk9;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  int n_vld8 = 0, n_perr8 = 0, n_serr8 = 0, n_brk8 = 0, n_vld9 = 0, n_serr9 = 0;
  ev_t q8[$];
  ev_t q9[$];
  logic [8:0] exp_pd8 = '0;
  logic [8:0] exp_pd9 = '0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_rx_multi_frame #(
    .DATA_WIDTH(8),
    .PRESCALE_WIDTH(6)
  ) u_dut8 (
    .CLK(CLK), .RST_N(RST_N), .RX_IN(rx8), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STOP2_EN(STOP2_EN), .Prescale(Prescale), .P_DATA(pd8), .DATA_VLD(vld8),
    .PAR_ERR(perr8), .STP_ERR(serr8)
`ifdef UART_RX_BREAK_DET_EN
    , .BREAK_DET(brk8)
`endif
  );

  uart_rx_multi_frame #(
    .DATA_WIDTH(9),
    .PRESCALE_WIDTH(6)
  ) u_dut9 (
    .CLK(CLK), .RST_N(RST_N), .RX_IN(rx9), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STOP2_EN(STOP2_EN), .Prescale(Prescale), .P_DATA(pd9), .DATA_VLD(vld9),
    .PAR_ERR(perr9), .STP_ERR(serr9)
`ifdef UART_RX_BREAK_DET_EN
    , .BREAK_DET(brk9)
`endif
  );

`ifndef UART_RX_BREAK_DET_EN
  assign brk8 = 1'b0;
  assign brk9 = 1'b0;
`endif

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  task automatic check_dut(input bit is9, input logic vld, input logic perr, input logic serr,
                           input logic brk, input logic [8:0] pd);
    ev_t ev;
    logic [8:0] exp_pd;
    ev.cyc = 0; ev.vld = 1'b0; ev.perr = 1'b0; ev.serr = 1'b0; ev.brk = 1'b0; ev.data = '0;
    if (!RST_N) begin
      if (is9) begin q9.delete(); exp_pd9 = '0; end
      else begin q8.delete(); exp_pd8 = '0; end
    end else if (is9) begin
      if (q9.size() > 0 && q9[0].cyc == cyc) ev = q9.pop_front();
      if (ev.vld) exp_pd9 = ev.data;
    end else begin
      if (q8.size() > 0 && q8[0].cyc == cyc) ev = q8.pop_front();
      if (ev.vld) exp_pd8 = ev.data;
    end
    exp_pd = is9 ? exp_pd9 : exp_pd8;
    check_eq(is9 ? "dut9_outputs" : "dut8_outputs",
             {19'b0, vld, perr, serr, brk, pd}, {19'b0, ev.vld, ev.perr, ev.serr, ev.brk, exp_pd});
  endtask

  always @(negedge CLK) begin
    check_dut(1'b0, vld8, perr8, serr8, brk8, {1'b0, pd8});
    check_dut(1'b1, vld9, perr9, serr9, brk9, pd9);
    if (vld8) n_vld8++;
    if (perr8) n_perr8++;
    if (serr8) n_serr8++;
    if (brk8) n_brk8++;
    if (vld9) n_vld9++;
    if (serr9) n_serr9++;
  end

  // All drive tasks are entered and left 1 time unit after a rising edge.
  task automatic tick(input int unsigned n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic set_rx(input bit is9, input logic v);
    if (is9) rx9 = v; else rx8 = v;
  endtask

  task automatic drive_bit(input bit is9, input logic v, input int unsigned p);
    set_rx(is9, v);
    tick(p);
  endtask

  task automatic send_frame(input bit is9, input logic [8:0] data, input int unsigned pin,
                            input bit pen, input bit ptyp, input bit pflip, input bit s2,
                            input logic stop1, input logic stop2);
    int unsigned p, nb;
    logic [8:0] d;
    logic par_sent, par_bad, stop_bad;
    ev_t ev;
    p = (pin == 16 || pin == 32) ? pin : 8;
    nb = is9 ? 9 : 8;
    d = is9 ? data : {1'b0, data[7:0]};
    par_sent = (^d) ^ ptyp ^ pflip;
    par_bad = pen && (par_sent != ((^d) ^ ptyp));
    stop_bad = !stop1 || (s2 && !stop2);
`ifdef UART_RX_BREAK_DET_EN
    ev.brk = (d == 0) && !(pen && par_sent) && !stop1 && !(s2 && stop2);
`else
    ev.brk = 1'b0;
`endif
    ev.perr = par_bad && !ev.brk;
    ev.serr = stop_bad && !ev.brk;
    ev.vld = !ev.brk && !par_bad && !stop_bad;
    ev.data = d;
    PAR_EN = pen; PAR_TYP = ptyp; STOP2_EN = s2; Prescale = 6'(pin);
    set_rx(is9, 1'b0);
    tick(3);
    // Configuration is latched by now; scramble it to show it no longer matters.
    PAR_EN = ~pen; PAR_TYP = ~ptyp; STOP2_EN = ~s2; Prescale = (p == 8) ? 6'd32 : 6'd8;
    tick(p - 3);
    for (int unsigned i = 0; i < nb; i++) drive_bit(is9, d[i], p);
    if (pen) drive_bit(is9, par_sent, p);
    if (s2) drive_bit(is9, stop1, p);
    ev.cyc = cyc + p / 2 + 5;
    if (is9) q9.push_back(ev); else q8.push_back(ev);
    drive_bit(is9, s2 ? stop2 : stop1, p);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: bench did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    @(negedge CLK);
    check_eq("reset_pdata8", {24'b0, pd8}, 32'h0);
    check_eq("reset_flags8", {29'b0, vld8, perr8, serr8}, 32'h0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    tick(20);

    // 1: 8N1 at x32
    send_frame(1'b0, 9'h0A5, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(64);
    check_eq("t1_pdata", {24'b0, pd8}, 32'hA5);
    check_eq("t1_vld_count", n_vld8, 1);

    // 2: even parity, wrong parity bit
    send_frame(1'b0, 9'h041, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(32);
    check_eq("t2_pdata_held", {24'b0, pd8}, 32'hA5);
    check_eq("t2_perr_count", n_perr8, 1);
    check_eq("t2_vld_count", n_vld8, 1);

    // 3: bad stop bit, then two good frames back-to-back
    send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1, 8);
    send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(1'b0, 9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(16);
    check_eq("t3_serr_count", n_serr8, 1);
    check_eq("t3_vld_count", n_vld8, 3);
    check_eq("t3_pdata", {24'b0, pd8}, 32'hC3);

    // 4: 2-cycle start glitch, then a good frame
    PAR_EN = 1'b0; STOP2_EN = 1'b0; Prescale = 6'd16;
    set_rx(1'b0, 1'b0);
    tick(2);
    drive_bit(1'b0, 1'b1, 48);
    check_eq("t4_glitch_pulses", n_vld8 + n_perr8 + n_serr8, 5);
    send_frame(1'b0, 9'h05A, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(32);
    check_eq("t4_pdata", {24'b0, pd8}, 32'h5A);
    check_eq("t4_vld_count", n_vld8, 4);

    // Illegal prescale 5 behaves as 8
    send_frame(1'b0, 9'h096, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(16);
    check_eq("illegal_prescale_pdata", {24'b0, pd8}, 32'h96);

    // 5: 9-bit, two stop bits, second one bad, then resend
    send_frame(1'b1, 9'h1F3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1, 16);
    send_frame(1'b1, 9'h1F3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(32);
    check_eq("t5_serr_count", n_serr9, 1);
    check_eq("t5_vld_count", n_vld9, 1);
    check_eq("t5_pdata", {23'b0, pd9}, 32'h1F3);

    // 6: reset in the middle of data bit 4
    PAR_EN = 1'b0; STOP2_EN = 1'b0; Prescale = 6'd16;
    drive_bit(1'b0, 1'b0, 16);
    drive_bit(1'b0, 1'b1, 16);
    drive_bit(1'b0, 1'b0, 16);
    drive_bit(1'b0, 1'b0, 16);
    drive_bit(1'b0, 1'b0, 16);
    drive_bit(1'b0, 1'b0, 8);
    RST_N = 1'b0;
    set_rx(1'b0, 1'b1);
    tick(4);
    check_eq("t6_reset_outputs", {20'b0, vld8, perr8, serr8, 1'b0, pd8}, 32'h0);
    RST_N = 1'b1;
    tick(40);
    check_eq("t6_no_pulse", n_vld8, 5);
    send_frame(1'b0, 9'h081, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(32);
    check_eq("t6_pdata", {24'b0, pd8}, 32'h81);

    // 7: all-zero line, held low, then recovery
    send_frame(1'b0, 9'h000, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(32);
    drive_bit(1'b0, 1'b1, 48);
`ifdef UART_RX_BREAK_DET_EN
    check_eq("t7_break_count", n_brk8, 1);
    check_eq("t7_serr_count", n_serr8, 1);
`else
    check_eq("t7_serr_count", n_serr8, 2);
`endif
    send_frame(1'b0, 9'h055, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(32);
    check_eq("t7_recover_pdata", {24'b0, pd8}, 32'h55);
    check_eq("final_vld_count", n_vld8, 7);
    check_eq("final_perr_count", n_perr8, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
